// File: rtl/park_pkg.sv
// Shared types and helpers for the multi-level parking controller.
// Optional build macro: PARK_HYST_EN enables descent hysteresis in
// descent_thr(); without it the HYST value passed in has no effect.
package park_pkg;

    // Floor FSM states; one-hot so that a corrupted register is detectable
    typedef enum logic [1:0] {
        FILL = 2'b01,
        FULL = 2'b10
    } park_state_e;

    // Floor that should be filling for a given occupancy: 0 when empty,
    // otherwise the floor holding the most recently parked car.
    function automatic int unsigned target_floor(input int unsigned cnt,
                                                 input int unsigned slots);
        int unsigned tgt;
        tgt = 0;
        if (cnt != 0) begin
            tgt = (cnt - 1) / slots;
        end
        return tgt;
    endfunction

    // Highest occupancy at which the fill floor may step down from floor f.
    // With hysteresis the occupancy must fall HYST slots further below the
    // floor boundary, which stops the floor toggling when cars oscillate
    // around that boundary.
    function automatic int descent_thr(input int unsigned f,
                                       input int unsigned slots,
                                       input int unsigned hyst);
        bit hyst_on;
        int thr;
`ifdef PARK_HYST_EN
        hyst_on = 1'b1;
`else
        hyst_on = 1'b0;
`endif
        thr = int'(f * slots);
        if (hyst_on) begin
            thr = thr - int'(hyst);
        end
        return thr;
    endfunction

endpackage

// File: rtl/park_occ_counter.sv
// Saturating occupancy counter for the car park, plus the one-cycle
// rejected-entry and spurious-exit pulses.
module park_occ_counter #(
    parameter int unsigned CAP = 12,
    parameter int unsigned CW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          car_in,
    input  logic          car_out,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          rej_in,
    output logic          err_out
);

    logic [CW-1:0] count_d;
    logic          rej_d;
    logic          err_d;

    // Next occupancy and error pulses from the pre-edge count
    always_comb begin
        count_d = count;
        rej_d   = 1'b0;
        err_d   = 1'b0;
        unique case ({car_in, car_out})
            2'b10: begin
                if (count < CW'(CAP)) begin
                    count_d = count + CW'(1);
                end else begin
                    rej_d = 1'b1;
                end
            end
            2'b01: begin
                if (count != '0) begin
                    count_d = count - CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                // both high cancel out; neither high holds
            end
        endcase
    end

    // Occupancy register; empty is registered alongside it from count_d
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            empty   <= 1'b1;
            rej_in  <= 1'b0;
            err_out <= 1'b0;
        end else begin
            count   <= count_d;
            empty   <= (count_d == '0);
            rej_in  <= rej_d;
            err_out <= err_d;
        end
    end

endmodule

// File: rtl/park_level_ctrl.sv
// Parking-occupancy controller for a multi-level car park: counts entry and
// exit pulses, walks the fill floor one step per clock toward the target
// floor, and flags full/empty/rejected-entry/spurious-exit.
// Optional build macro: PARK_HYST_EN (descent hysteresis of HYST slots).
module park_level_ctrl
    import park_pkg::*;
#(
    parameter int unsigned NUM_FLOORS      = 3,
    parameter int unsigned SLOTS_PER_FLOOR = 4,
    parameter int unsigned HYST            = 1,
    localparam int unsigned CAP = NUM_FLOORS * SLOTS_PER_FLOOR,
    localparam int unsigned CW  = $clog2(CAP + 1),
    localparam int unsigned FW  = $clog2(NUM_FLOORS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          car_in,
    input  logic          car_out,
    output logic [CW-1:0] count,
    output logic [FW-1:0] floor,
    output logic          full,
    output logic          empty,
    output logic          rej_in,
    output logic          err_out
);

    localparam int unsigned TOP_FLOOR = NUM_FLOORS - 1;

    park_state_e   state_q;
    park_state_e   state_d;
    logic [FW-1:0] f_q;
    logic [FW-1:0] f_d;
    logic [FW-1:0] floor_d;
    logic          full_d;
    int unsigned   cnt_i;
    int unsigned   f_i;
    int unsigned   tgt;
    int            thr;

    park_occ_counter #(
        .CAP (CAP),
        .CW  (CW)
    ) u_occ (
        .clk     (clk),
        .rst     (rst),
        .car_in  (car_in),
        .car_out (car_out),
        .count   (count),
        .empty   (empty),
        .rej_in  (rej_in),
        .err_out (err_out)
    );

    // Floor FSM next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        cnt_i   = 32'(count);
        f_i     = 32'(f_q);
        tgt     = target_floor(cnt_i, SLOTS_PER_FLOOR);
        thr     = descent_thr(f_i, SLOTS_PER_FLOOR, HYST);
        floor_d = '0;
        full_d  = 1'b0;

        unique case (state_q)
            FILL: begin
                if (f_i > TOP_FLOOR) begin
                    // floor register outside the park: restart at ground
                    f_d = '0;
                end else if (cnt_i == CAP && f_i == TOP_FLOOR) begin
                    state_d = FULL;
                end else if (tgt > f_i) begin
                    f_d = f_q + FW'(1);
                end else if (tgt < f_i && int'(cnt_i) <= thr) begin
                    f_d = f_q - FW'(1);
                end
            end
            FULL: begin
                // floor stays on the top level when leaving FULL
                f_d = FW'(TOP_FLOOR);
                if (cnt_i < CAP) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                f_d     = '0;
            end
        endcase

        if (state_d == FULL) begin
            floor_d = FW'(TOP_FLOOR);
            full_d  = 1'b1;
        end else begin
            floor_d = f_d;
            full_d  = 1'b0;
        end
    end

    // State, floor register and registered floor/full outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            f_q     <= '0;
            floor   <= '0;
            full    <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            floor   <= floor_d;
            full    <= full_d;
        end
    end

endmodule

// File: tb/tb_park_level_ctrl.sv
// Bench for park_level_ctrl: constant vector table, directed corner
// sequences and a randomized run against an occupancy/floor model.
module tb_park_level_ctrl;

    localparam int unsigned N   = 3;
    localparam int unsigned S   = 4;
    localparam int unsigned H   = 1;
    localparam int unsigned CAP = N * S;
    localparam int unsigned CW  = $clog2(CAP + 1);
    localparam int unsigned FW  = $clog2(N);
`ifdef PARK_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          car_in;
    logic          car_out;
    logic [CW-1:0] count;
    logic [FW-1:0] floor;
    logic          full;
    logic          empty;
    logic          rej_in;
    logic          err_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: occupancy, fill floor, full flag, pending pulses
    int m_cnt  = 0;
    int m_f    = 0;
    bit m_full = 1'b0;
    bit m_rej  = 1'b0;
    bit m_err  = 1'b0;

    typedef struct {
        bit r;
        bit ci;
        bit co;
        int cnt;
        int flr;
        bit fu;
        bit em;
        bit rj;
        bit er;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    park_level_ctrl #(
        .NUM_FLOORS      (N),
        .SLOTS_PER_FLOOR (S),
        .HYST            (H)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .car_in  (car_in),
        .car_out (car_out),
        .count   (count),
        .floor   (floor),
        .full    (full),
        .empty   (empty),
        .rej_in  (rej_in),
        .err_out (err_out)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of the park rules, all decisions taken on pre-edge values
    function automatic void model_step(input bit r, input bit ci, input bit co);
        int tgt;
        int lim;
        if (r) begin
            m_cnt = 0; m_f = 0; m_full = 0; m_rej = 0; m_err = 0;
            return;
        end
        tgt = (m_cnt == 0) ? 0 : (m_cnt - 1) / int'(S);
        lim = m_f * int'(S) - (HYST_ON ? int'(H) : 0);
        if (m_full) begin
            if (m_cnt < int'(CAP)) m_full = 0;
        end else if (m_cnt == int'(CAP) && m_f == int'(N) - 1) begin
            m_full = 1;
        end else if (tgt > m_f) begin
            m_f = m_f + 1;
        end else if (tgt < m_f && m_cnt <= lim) begin
            m_f = m_f - 1;
        end
        m_rej = 0;
        m_err = 0;
        if (ci && !co) begin
            if (m_cnt < int'(CAP)) m_cnt++; else m_rej = 1;
        end else if (co && !ci) begin
            if (m_cnt > 0) m_cnt--; else m_err = 1;
        end
    endfunction

    // Drive one cycle, advance the model and compare every output
    task automatic step(input bit r, input bit ci, input bit co);
        rst = r; car_in = ci; car_out = co;
        @(posedge clk);
        model_step(r, ci, co);
        #1;
        check("count",   int'(count),   m_cnt);
        check("floor",   int'(floor),   m_full ? int'(N) - 1 : m_f);
        check("full",    int'(full),    int'(m_full));
        check("empty",   int'(empty),   int'(m_cnt == 0));
        check("rej_in",  int'(rej_in),  int'(m_rej));
        check("err_out", int'(err_out), int'(m_err));
    endtask

    function automatic void add(input bit r, input bit ci, input bit co,
                                input int cnt, input int flr, input bit fu,
                                input bit em, input bit rj, input bit er);
        vec_t v;
        v.r = r; v.ci = ci; v.co = co; v.cnt = cnt; v.flr = flr;
        v.fu = fu; v.em = em; v.rj = rj; v.er = er;
        vecs.push_back(v);
    endfunction

    task automatic repeat_step(input int n, input bit ci, input bit co);
        for (int k = 0; k < n; k++) step(1'b0, ci, co);
    endtask

    initial begin
        rst = 1'b1; car_in = 1'b0; car_out = 1'b0;

        // Fill from empty to beyond capacity, then the exit error cases
        add(1, 0, 0,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0,  1, 0, 0, 0, 0, 0);
        add(0, 1, 0,  2, 0, 0, 0, 0, 0);
        add(0, 1, 0,  3, 0, 0, 0, 0, 0);
        add(0, 1, 0,  4, 0, 0, 0, 0, 0);
        add(0, 1, 0,  5, 0, 0, 0, 0, 0);
        add(0, 0, 0,  5, 1, 0, 0, 0, 0);
        add(0, 1, 0,  6, 1, 0, 0, 0, 0);
        add(0, 1, 0,  7, 1, 0, 0, 0, 0);
        add(0, 1, 0,  8, 1, 0, 0, 0, 0);
        add(0, 1, 0,  9, 1, 0, 0, 0, 0);
        add(0, 1, 0, 10, 2, 0, 0, 0, 0);
        add(0, 1, 0, 11, 2, 0, 0, 0, 0);
        add(0, 1, 0, 12, 2, 0, 0, 0, 0);
        add(0, 1, 0, 12, 2, 1, 0, 1, 0);
        add(0, 0, 0, 12, 2, 1, 0, 0, 0);
        add(0, 1, 1, 12, 2, 1, 0, 0, 0);
        add(1, 0, 0,  0, 0, 0, 1, 0, 0);
        add(0, 0, 1,  0, 0, 0, 1, 0, 1);
        add(0, 1, 1,  0, 0, 0, 1, 0, 0);
        add(0, 0, 0,  0, 0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].ci, vecs[i].co);
            check($sformatf("tbl%0d_count", i), int'(count),   vecs[i].cnt);
            check($sformatf("tbl%0d_floor", i), int'(floor),   vecs[i].flr);
            check($sformatf("tbl%0d_full", i),  int'(full),    int'(vecs[i].fu));
            check($sformatf("tbl%0d_empty", i), int'(empty),   int'(vecs[i].em));
            check($sformatf("tbl%0d_rej", i),   int'(rej_in),  int'(vecs[i].rj));
            check($sformatf("tbl%0d_err", i),   int'(err_out), int'(vecs[i].er));
        end

        // Descent across the floor 1 / floor 0 boundary
        step(1'b1, 1'b0, 1'b0);
        repeat_step(8, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("hy_start_floor", int'(floor), 1);
        repeat_step(4, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("hy_cnt4", int'(count), 4);
        check("hy_floor_at4", int'(floor), HYST_ON ? 1 : 0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("hy_floor_at3", int'(floor), 0);

        // Full park drained one car per cycle down to one
        step(1'b1, 1'b0, 1'b0);
        repeat_step(12, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("bu_full", int'(full), 1);
        step(1'b0, 1'b0, 1'b1);
        check("bu_cnt11", int'(count), 11);
        check("bu_full_at11", int'(full), 1);
        step(1'b0, 1'b0, 1'b1);
        check("bu_full_fall", int'(full), 0);
        check("bu_floor_top", int'(floor), 2);
        repeat_step(9, 1'b0, 1'b1);
        check("bu_cnt1", int'(count), 1);
        repeat_step(2, 1'b0, 1'b0);
        check("bu_floor0", int'(floor), 0);

        // Reset in the middle of operation, with an entry request present
        step(1'b1, 1'b0, 1'b0);
        repeat_step(7, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rs_cnt7", int'(count), 7);
        check("rs_floor1", int'(floor), 1);
        step(1'b1, 1'b1, 1'b0);
        check("rs_count", int'(count), 0);
        check("rs_floor", int'(floor), 0);
        check("rs_full", int'(full), 0);
        check("rs_empty", int'(empty), 1);

        // Randomized traffic in phases biased toward filling or draining
        for (int i = 0; i < 4000; i++) begin
            int p_in;
            int phase;
            bit ci;
            bit co;
            bit r;
            phase = (i / 250) % 3;
            p_in  = (phase == 0) ? 75 : ((phase == 1) ? 25 : 50);
            ci = ($urandom_range(0, 99) < p_in);
            co = ($urandom_range(0, 99) < (100 - p_in));
            r  = ($urandom_range(0, 599) == 0);
            step(r, ci, co);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
